// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - channel synchroniser: address latch, FIFO steering and per-channel read-timeout watchdog
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err,
    output logic [ADDR_W-1:0] sel_ch
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0] sel;
    logic              sel_valid;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] idle;
    logic [NUM_CH-1:0] expire;
    logic              sel_expire;
    logic              addr_ok;

    assign vld_out = ~empty;
    assign idle    = vld_out & ~read_enb;
    assign addr_ok = {1'b0, data_in} < NUM_CH_EXT;
    assign sel_ch  = sel;

    always_comb begin
        expire     = '0;
        sel_expire = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            expire[i] = idle[i] && (cnt[i] == CNT_LAST);
            if (sel == ADDR_W'(i)) sel_expire = expire[i];
        end
    end

    // Steering decodes the registered selection only, so a same-cycle detect_add still uses the old channel
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_valid && (sel == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel       <= '0;
            sel_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else if (detect_add) begin
            sel       <= data_in;
            sel_valid <= addr_ok;
            addr_err  <= !addr_ok;
        end else begin
            addr_err <= 1'b0;
            // A timed-out destination FIFO aborts the packet in flight
            if (sel_valid && sel_expire) sel_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            soft_reset <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!idle[i]) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (expire[i]) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt[i]        <= cnt[i] + CNT_W'(1);
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_sync_n.sv
// tb/tb_router_sync_n.sv - directed scoreboard bench for router_sync_n
module tb_router_sync_n;

    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 30;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [ADDR_W-1:0] data_in = '0;
    logic              detect_add = 1'b0;
    logic              write_enb_reg = 1'b0;
    logic [NUM_CH-1:0] full = '0;
    logic [NUM_CH-1:0] empty = '1;
    logic [NUM_CH-1:0] read_enb = '0;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_err;
    logic [ADDR_W-1:0] sel_ch;

    int compared   = 0;
    int mismatched = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .data_in(data_in), .detect_add(detect_add),
        .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
        .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
        .soft_reset(soft_reset), .addr_err(addr_err), .sel_ch(sel_ch)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic ex(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        compared++;
        if (val_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                mismatched++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    initial begin
        // Reset and defaults
        write_enb_reg = 1'b1;
        empty = 3'b101;
        tick(2);
        ex("rst_we", 32'h0);      chk(32'(write_enb));
        ex("rst_ff", 32'h0);      chk(32'(fifo_full));
        ex("rst_sr", 32'h0);      chk(32'(soft_reset));
        ex("rst_ae", 32'h0);      chk(32'(addr_err));
        ex("rst_sel", 32'h0);     chk(32'(sel_ch));
        ex("rst_vld", 32'h2);     chk(32'(vld_out));
        empty = 3'b111;
        resetn = 1'b1;
        tick(1);
        ex("post_rst_we", 32'h0); chk(32'(write_enb));
        ex("post_rst_sr", 32'h0); chk(32'(soft_reset));

        // Steering to channel 2
        data_in = 2'd2; detect_add = 1'b1; full = 3'b100;
        #1;
        ex("steer_before_we", 32'h0); chk(32'(write_enb));
        tick(1);
        detect_add = 1'b0;
        #1;
        ex("steer_we", 32'h4);    chk(32'(write_enb));
        ex("steer_ff", 32'h1);    chk(32'(fifo_full));
        ex("steer_sel", 32'h2);   chk(32'(sel_ch));
        full = 3'b000;
        #1;
        ex("steer_ff_clr", 32'h0); chk(32'(fifo_full));

        // Out-of-range address, back-to-back
        full = 3'b111; data_in = 2'd3; detect_add = 1'b1;
        tick(1);
        ex("aerr_pulse1", 32'h1); chk(32'(addr_err));
        ex("aerr_we", 32'h0);     chk(32'(write_enb));
        ex("aerr_ff", 32'h0);     chk(32'(fifo_full));
        tick(1);
        ex("aerr_pulse2", 32'h1); chk(32'(addr_err));
        detect_add = 1'b0;
        tick(1);
        ex("aerr_clear", 32'h0);  chk(32'(addr_err));
        ex("aerr_we_hold", 32'h0); chk(32'(write_enb));
        data_in = 2'd1; detect_add = 1'b1;
        tick(1);
        detect_add = 1'b0;
        #1;
        ex("aerr_recover_we", 32'h2); chk(32'(write_enb));
        ex("aerr_recover_ae", 32'h0); chk(32'(addr_err));

        // detect_add with write_enb_reg in the same cycle uses the old selection
        data_in = 2'd0; detect_add = 1'b1;
        #1;
        ex("same_cyc_old", 32'h2); chk(32'(write_enb));
        tick(1);
        detect_add = 1'b0;
        #1;
        ex("same_cyc_new", 32'h1); chk(32'(write_enb));

        // Timeout on channel 0 while selection points at channel 2
        data_in = 2'd2; detect_add = 1'b1;
        tick(1);
        detect_add = 1'b0; write_enb_reg = 1'b0; full = '0;
        empty = 3'b110; read_enb = '0;
        for (int k = 1; k <= 61; k++) begin
            tick(1);
            if (k == 29 || k == 31 || k == 59 || k == 61) begin
                ex($sformatf("to_quiet_%0d", k), 32'h0); chk(32'(soft_reset));
            end
            if (k == 30 || k == 60) begin
                ex($sformatf("to_pulse_%0d", k), 32'h1); chk(32'(soft_reset));
            end
        end

        // read_enb restarts the count
        empty = 3'b111;
        tick(1);
        empty = 3'b110;
        tick(29);
        ex("rd_pre", 32'h0); chk(32'(soft_reset));
        read_enb = 3'b001;
        tick(1);
        read_enb = 3'b000;
        tick(29);
        ex("rd_quiet_29", 32'h0); chk(32'(soft_reset));
        tick(1);
        ex("rd_pulse_30", 32'h1); chk(32'(soft_reset));

        // Abort: selected channel 1 times out
        empty = 3'b111;
        tick(1);
        data_in = 2'd1; detect_add = 1'b1;
        tick(1);
        detect_add = 1'b0; write_enb_reg = 1'b1;
        #1;
        ex("abort_we_sel", 32'h2); chk(32'(write_enb));
        empty = 3'b101;
        tick(29);
        ex("abort_we_pre", 32'h2); chk(32'(write_enb));
        tick(1);
        ex("abort_sr", 32'h2);     chk(32'(soft_reset));
        ex("abort_we_cut", 32'h0); chk(32'(write_enb));
        tick(1);
        ex("abort_we_hold", 32'h0); chk(32'(write_enb));
        ex("abort_sel", 32'h1);     chk(32'(sel_ch));

        // Reset mid-count
        write_enb_reg = 1'b0;
        empty = 3'b111;
        tick(1);
        empty = 3'b110;
        tick(20);
        resetn = 1'b0;
        #1;
        ex("mid_rst_sr", 32'h0); chk(32'(soft_reset));
        tick(1);
        resetn = 1'b1;
        tick(10);
        ex("mid_rst_no_partial", 32'h0); chk(32'(soft_reset));
        tick(19);
        ex("mid_rst_quiet_29", 32'h0); chk(32'(soft_reset));
        tick(1);
        ex("mid_rst_pulse_30", 32'h1); chk(32'(soft_reset));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
